dat_fifo_buffer: RTL and testbench

Single-clock circular FIFO that buffers block data words between the host register side and the DAT line engine. One instance serves as the transmit buffer: host writes words, DAT pops them through `tx_buf_rd_enb` and sees `tx_buf_empty`/`tx_buf_dout_in`. A second instance serves as the receive buffer: DAT pushes words through `rx_buf_wr_enb`/`rx_buf_din_out` and sees `rx_buf_full`. It provides occupancy count, almost-full/almost-empty flags, flush, and optional sticky error flags.

---
 rtl/dat_fifo_buffer_pkg.sv | 9 +
 rtl/dat_fifo_buffer_if.sv | 30 +++
 rtl/dat_fifo_mem.sv | 28 ++
 rtl/dat_fifo_buffer.sv | 78 +++++++
 tb/tb_dat_fifo_buffer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/dat_fifo_buffer_pkg.sv
// dat_fifo_buffer_pkg: shared FIFO sizing constants used by the DAT engine, the register block and the buffer
//   FIFO_WIDTH      - data word width
//   FIFO_ADDR_WIDTH - buffer pointer width
//   FIFO_DEPTH      - default buffer depth, 2^FIFO_ADDR_WIDTH
package dat_fifo_buffer_pkg;
    localparam int FIFO_WIDTH      = 32;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;
endpackage

// File: rtl/dat_fifo_buffer_if.sv
// dat_fifo_buffer_if: push/pop bus between a buffer user and dat_fifo_buffer
//   master - the user: drives flush, wr_enb, din, rd_enb; sees data, occupancy and flags
//   slave  - the buffer: the mirror image of master
interface dat_fifo_buffer_if import dat_fifo_buffer_pkg::*; #(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) ();
    logic                  flush;
    logic                  wr_enb;
    logic [WIDTH-1:0]      din;
    logic                  rd_enb;
    logic [WIDTH-1:0]      dout;
    logic                  buf_empty;
    logic                  buf_full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output flush, wr_enb, din, rd_enb,
        input  dout, buf_empty, buf_full, almost_full, almost_empty, word_cnt, overflow_err, underflow_err
    );

    modport slave (
        input  flush, wr_enb, din, rd_enb,
        output dout, buf_empty, buf_full, almost_full, almost_empty, word_cnt, overflow_err, underflow_err
    );
endinterface

// File: rtl/dat_fifo_mem.sv
// dat_fifo_mem: DEPTH x WIDTH storage array, synchronous write port and registered read port
//   host_clk, rst_L          - clock and synchronous active-low reset (clears only the read register)
//   wr_en, wr_addr, wr_data  - write port
//   rd_en, rd_addr, rd_data  - read port; rd_data loads on rd_en and holds otherwise
module dat_fifo_mem import dat_fifo_buffer_pkg::*; #(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  host_clk,
    input  logic                  rst_L,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge host_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge host_clk) begin
        if (!rst_L) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/dat_fifo_buffer.sv
// dat_fifo_buffer: single-clock circular FIFO between the host register side and the DAT line engine
//   host_clk - clock, all state changes on the rising edge
//   rst_L    - synchronous active-low reset
//   bus      - dat_fifo_buffer_if.slave: flush, push (wr_enb/din), pop (rd_enb/dout), word_cnt,
//              buf_empty/buf_full, almost_full/almost_empty, overflow_err/underflow_err
// Define DAT_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they are tied to 0.
module dat_fifo_buffer import dat_fifo_buffer_pkg::*; #(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic        host_clk,
    input  logic        rst_L,
    dat_fifo_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  empty, full, push, pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    // Flush outranks push/pop, so a request on a flush edge must not touch memory or dout.
    assign push  = bus.wr_enb && !full  && !bus.flush;
    assign pop   = bus.rd_enb && !empty && !bus.flush;

    always_ff @(posedge host_clk) begin
        if (!rst_L || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
        end
    end

    dat_fifo_mem #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .host_clk (host_clk),
        .rst_L    (rst_L),
        .wr_en    (push && rst_L),
        .wr_addr  (wr_ptr),
        .wr_data  (bus.din),
        .rd_en    (pop && rst_L),
        .rd_addr  (rd_ptr),
        .rd_data  (bus.dout)
    );

    assign bus.word_cnt     = cnt;
    assign bus.buf_empty    = empty;
    assign bus.buf_full     = full;
    assign bus.almost_full  = (cnt >= CW'(AF_LEVEL));
    assign bus.almost_empty = (cnt <= CW'(AE_LEVEL));

`ifdef DAT_FIFO_ERR_FLAGS_EN
    logic ovf, udf;

    always_ff @(posedge host_clk) begin
        if (!rst_L || bus.flush) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf | (bus.wr_enb & full);
            udf <= udf | (bus.rd_enb & empty);
        end
    end

    assign bus.overflow_err  = ovf;
    assign bus.underflow_err = udf;
`else
    assign bus.overflow_err  = 1'b0;
    assign bus.underflow_err = 1'b0;
`endif
endmodule

// File: tb/tb_dat_fifo_buffer.sv
// tb_dat_fifo_buffer: directed self-checking bench for dat_fifo_buffer
module tb_dat_fifo_buffer;
    import dat_fifo_buffer_pkg::*;

`ifdef DAT_FIFO_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    logic [31:0] q [$];
    logic [31:0] e;

    dat_fifo_buffer_if bus ();

    dat_fifo_buffer dut (
        .host_clk (clk),
        .rst_L    (rst_L),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        bus.wr_enb = 1'b1;
        bus.din    = d;
        cyc();
        bus.wr_enb = 1'b0;
    endtask

    task automatic pop();
        bus.rd_enb = 1'b1;
        cyc();
        bus.rd_enb = 1'b0;
    endtask

    initial begin
        bus.flush  = 1'b0;
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        bus.din    = '0;
        cyc();
        cyc();
        rst_L = 1'b1;
        check("rst_cnt", 64'(bus.word_cnt), 0);
        check("rst_empty", 64'(bus.buf_empty), 1);
        check("rst_full", 64'(bus.buf_full), 0);
        check("rst_ae", 64'(bus.almost_empty), 1);
        check("rst_af", 64'(bus.almost_full), 0);
        check("rst_dout", 64'(bus.dout), 0);
        check("rst_ovf", 64'(bus.overflow_err), 0);
        check("rst_udf", 64'(bus.underflow_err), 0);

        for (int i = 0; i < 16; i++) begin
            push(32'(i));
            check("fill_cnt", 64'(bus.word_cnt), 64'(i + 1));
            check("fill_af", 64'(bus.almost_full), 64'(i + 1 >= 14));
            check("fill_ae", 64'(bus.almost_empty), 64'(i + 1 <= 2));
            check("fill_full", 64'(bus.buf_full), 64'(i == 15));
            check("fill_empty", 64'(bus.buf_empty), 0);
        end
        push(32'hDEAD_BEEF);
        check("ovf_cnt", 64'(bus.word_cnt), 16);
        check("ovf_flag", 64'(bus.overflow_err), 64'(ERR));

        for (int i = 0; i < 16; i++) begin
            pop();
            check("drain_dout", 64'(bus.dout), 64'(i));
            check("drain_cnt", 64'(bus.word_cnt), 64'(15 - i));
        end
        check("drain_empty", 64'(bus.buf_empty), 1);
        pop();
        check("udf_dout", 64'(bus.dout), 64'hF);
        check("udf_cnt", 64'(bus.word_cnt), 0);
        check("udf_flag", 64'(bus.underflow_err), 64'(ERR));

        for (int i = 0; i < 10; i++) push(32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            pop();
            check("wrap1_dout", 64'(bus.dout), 64'(32'hA5A5_0000 + 32'(i)));
        end
        for (int i = 0; i < 12; i++) push(32'hA5A5_0000 + 32'(i));
        check("wrap2_cnt", 64'(bus.word_cnt), 12);
        for (int i = 0; i < 12; i++) begin
            pop();
            check("wrap2_dout", 64'(bus.dout), 64'(32'hA5A5_0000 + 32'(i)));
        end
        check("wrap_cnt0", 64'(bus.word_cnt), 0);

        for (int i = 0; i < 5; i++) begin
            push(32'h100 + 32'(i));
            q.push_back(32'h100 + 32'(i));
        end
        for (int k = 0; k < 20; k++) begin
            bus.wr_enb = 1'b1;
            bus.rd_enb = 1'b1;
            bus.din    = 32'h200 + 32'(k);
            cyc();
            q.push_back(32'h200 + 32'(k));
            e = q.pop_front();
            check("sim_dout", 64'(bus.dout), 64'(e));
            check("sim_cnt", 64'(bus.word_cnt), 5);
        end
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        while (q.size() > 0) begin
            pop();
            e = q.pop_front();
            check("sim_drain", 64'(bus.dout), 64'(e));
        end
        check("sim_empty", 64'(bus.buf_empty), 1);
        bus.wr_enb = 1'b1;
        bus.rd_enb = 1'b1;
        bus.din    = 32'hCAFE;
        cyc();
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        check("empty_pp_cnt", 64'(bus.word_cnt), 1);
        check("empty_pp_dout", 64'(bus.dout), 64'(e));
        pop();
        check("empty_pp_pop", 64'(bus.dout), 64'hCAFE);

        for (int i = 0; i < 7; i++) push(32'h300 + 32'(i));
        check("pre_flush_cnt", 64'(bus.word_cnt), 7);
        check("pre_flush_ovf", 64'(bus.overflow_err), 64'(ERR));
        check("pre_flush_udf", 64'(bus.underflow_err), 64'(ERR));
        bus.flush  = 1'b1;
        bus.wr_enb = 1'b1;
        bus.din    = 32'hDEAD;
        cyc();
        bus.flush  = 1'b0;
        bus.wr_enb = 1'b0;
        check("flush_cnt", 64'(bus.word_cnt), 0);
        check("flush_empty", 64'(bus.buf_empty), 1);
        check("flush_ae", 64'(bus.almost_empty), 1);
        check("flush_dout", 64'(bus.dout), 64'hCAFE);
        check("flush_ovf", 64'(bus.overflow_err), 0);
        check("flush_udf", 64'(bus.underflow_err), 0);
        push(32'h77);
        pop();
        check("post_flush_dout", 64'(bus.dout), 64'h77);
        check("post_flush_cnt", 64'(bus.word_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
